rsa_encrypt: RTL and testbench

- Encryption-side counterpart of the RSA decrypt block: computes c = m^e mod n for public exponent e.
- Uses right-to-left binary (square-and-multiply) exponentiation.
- Each modular product is done by an internal bit-serial interleaved modular multiplier, one bit per cycle, so there is no wide combinational multiply or %.
- Start/done handshake; sits in front of the link/storage path feeding the decrypt block.

---
 rtl/rsa_encrypt_if.sv | 22 ++
 rtl/rsa_encrypt.sv | 141 ++++++++++++++
 tb/tb_rsa_encrypt.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_encrypt_if.sv
// rsa_encrypt_if: start/done handshake and operand bus for rsa_encrypt.
//   start      request, sampled only while the block is idle
//   m, e, n    plaintext, public exponent and modulus, latched on accept
//   busy       high while an operation is in progress
//   done       one-cycle pulse when c/err are updated
//   err        operand error flag, valid with done, held until next done
//   c          ciphertext, valid with done, held until next done
interface rsa_encrypt_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] c;

    modport master (output start, m, e, n, input busy, done, err, c);
    modport slave  (input start, m, e, n, output busy, done, err, c);
endinterface

// File: rtl/rsa_encrypt.sv
// rsa_encrypt: computes c = m^e mod n by right-to-left square-and-multiply.
// Every modular product goes through a bit-serial interleaved multiplier
// (one bit of the left operand per cycle, WIDTH cycles per product).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any operation silently
//   bus    rsa_encrypt_if slave modport (start/m/e/n in, busy/done/err/c out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; latches operands on accept
// S_CHECK | operand validation, early exit for errors and e == 0
// S_BIT   | inspects the current exponent LSB
// S_MUL   | R <= R * base mod n (WIDTH cycles)
// S_SHIFT | drops the consumed exponent bit, finishes when e is used up
// S_SQR   | base <= base * base mod n (WIDTH cycles)
// S_DONE  | one-cycle done pulse
module rsa_encrypt #(
    parameter int WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    rsa_encrypt_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_BIT, S_MUL, S_SHIFT, S_SQR, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] base_r, e_r, n_r, r_r, c_r;
    logic             err_r;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt;

    logic             mm_last;
    logic             op_bad;
    logic             e_last;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] a_op;
    logic             a_bit;
    logic [WIDTH+1:0] nx, sum, sub1, sub2;

    assign mm_last = (cnt == CW'(WIDTH-1));
    assign op_bad  = (n_r < WIDTH'(2)) || (base_r >= n_r);
    assign e_last  = (e_r[WIDTH-1:1] == '0);

    // Interleaved modular multiply step. acc < n on entry, so 2*acc + b < 3n
    // fits in WIDTH+2 bits and two conditional subtractions restore acc < n.
    // Both products use base as the right operand; only the left one differs.
    assign bit_idx = CW'(WIDTH-1) - cnt;
    assign a_op    = (state == S_SQR) ? base_r : r_r;
    assign a_bit   = a_op[bit_idx];
    assign nx      = {2'b00, n_r};
    assign sum     = (acc << 1) + (a_bit ? {2'b00, base_r} : '0);
    assign sub1    = (sum  >= nx) ? sum  - nx : sum;
    assign sub2    = (sub1 >= nx) ? sub1 - nx : sub1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_CHECK;
            S_CHECK: begin
                if (op_bad || e_r == '0) state_nx = S_DONE;
                else                     state_nx = S_BIT;
            end
            S_BIT:   state_nx = e_r[0] ? S_MUL : S_SHIFT;
            S_MUL:   if (mm_last) state_nx = S_SHIFT;
            S_SHIFT: state_nx = e_last ? S_DONE : S_SQR;
            S_SQR:   if (mm_last) state_nx = S_BIT;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0;
            e_r    <= '0;
            n_r    <= '0;
            r_r    <= '0;
            c_r    <= '0;
            err_r  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        base_r <= bus.m;
                        e_r    <= bus.e;
                        n_r    <= bus.n;
                        r_r    <= WIDTH'(1);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_CHECK: begin
                    if (op_bad) begin
                        err_r <= 1'b1;
                        c_r   <= '0;
                    end else if (e_r == '0) begin
                        err_r <= 1'b0;
                        c_r   <= WIDTH'(1);
                    end
                end
                S_MUL, S_SQR: begin
                    if (mm_last) begin
                        if (state == S_MUL) r_r    <= sub2[WIDTH-1:0];
                        else                base_r <= sub2[WIDTH-1:0];
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= sub2;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    e_r <= e_r >> 1;
                    if (e_last) begin
                        c_r   <= r_r;
                        err_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.err  = err_r;
    assign bus.c    = c_r;
endmodule

// File: tb/tb_rsa_encrypt.sv
module tb_rsa_encrypt;
    localparam int W = 128;
    localparam int unsigned BUDGET = 30000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsa_encrypt_if #(.WIDTH(W)) bus();
    rsa_encrypt #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] c;
        logic         err;
        int unsigned  due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference: plain modular exponentiation with double-width products.
    function automatic void model(input logic [W-1:0] m, input logic [W-1:0] e,
                                  input logic [W-1:0] n, output logic [W-1:0] c,
                                  output logic err, output int unsigned lat);
        logic [2*W-1:0] r, b;
        int k, p;
        if (n < 2 || m >= n) begin
            c = '0; err = 1'b1; lat = 2;
            return;
        end
        err = 1'b0;
        if (e == '0) begin
            c = W'(1); lat = 2;
            return;
        end
        r = 1; b = {{W{1'b0}}, m}; k = 0; p = 0;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                r = (r * b) % n;
                p++;
                k = i;
            end
            b = (b * b) % n;
        end
        c = r[W-1:0];
        lat = 2 + 2 * (k + 1) + (p + k) * W;
    endfunction

    task automatic wait_idle();
        int unsigned t = 0;
        @(negedge clk);
        while (bus.busy && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", bus.busy, t);
            finish_now();
        end
    endtask

    // Returns at the negedge after the accept edge; acc is the accept cycle.
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                         input logic [W-1:0] xc, input logic xerr, input int unsigned lat,
                         output int unsigned acc);
        wait_idle();
        bus.m = m; bus.e = e; bus.n = n;
        bus.start = 1'b1;
        acc = cyc;
        sb.push_back('{xc, xerr, cyc + lat});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_model(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        logic [W-1:0] xc; logic xerr; int unsigned lat, acc;
        model(m, e, n, xc, xerr, lat);
        issue(m, e, n, xc, xerr, lat, acc);
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("busy_after_done", W'(bus.busy), W'(0));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required none (cycle %0d)", cyc);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("c", bus.c, x.c);
                    check("err", W'(bus.err), W'(x.err));
                    check("done_cycle", W'(cyc), W'(x.due));
                    check("busy_at_done", W'(bus.busy), W'(1));
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int unsigned acc, lat;
        logic [W-1:0] xc, m, e, n;
        logic xerr;

        bus.start = 1'b0; bus.m = '0; bus.e = '0; bus.n = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_err", W'(bus.err), W'(0));
        check("rst_c", bus.c, W'(0));
        rst_n = 1'b1;

        // Reference op with ignored start pulses at cycles 5 and 779..780.
        issue(W'(65), W'(17), W'(3233), W'(2790), 1'b0, 780, acc);
        while (cyc < acc + 5) @(negedge clk);
        bus.m = W'(7); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 779) @(negedge clk);
        bus.m = W'(11); bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;

        // Round trips (exponentiation with d=2753 undoes e=17 mod 3233).
        issue(W'(2790), W'(2753), W'(3233), W'(65), 1'b0, 2074, acc);
        issue(W'(123), W'(17), W'(3233), W'(855), 1'b0, 780, acc);
        issue(W'(855), W'(2753), W'(3233), W'(123), 1'b0, 2074, acc);

        // Boundaries.
        issue(W'(42), W'(0), W'(3233), W'(1), 1'b0, 2, acc);
        issue(W'(0), W'(17), W'(3233), W'(0), 1'b0, 780, acc);
        issue(W'(3232), W'(1), W'(3233), W'(3232), 1'b0, 132, acc);
        n = '1; m = n - 1;
        issue(m, W'(2), n, W'(1), 1'b0, 262, acc);

        // Errors, then a valid op clears err.
        issue(W'(0), W'(17), W'(1), W'(0), 1'b1, 2, acc);
        issue(W'(3233), W'(17), W'(3233), W'(0), 1'b1, 2, acc);
        issue(W'(65), W'(17), W'(3233), W'(2790), 1'b0, 780, acc);

        // Random full-width operands against the model.
        for (int i = 0; i < 6; i++) begin
            n = rnd128();
            n[W-1] = 1'b1;
            m = rnd128() % n;
            e = W'($urandom_range(1, 255));
            run_model(m, e, n);
        end
        // Random small operands, reaching error and e==0 paths too.
        for (int i = 0; i < 10; i++) begin
            run_model(W'($urandom_range(0, 25)), W'($urandom_range(0, 31)),
                      W'($urandom_range(0, 20)));
        end

        // Start held high: back-to-back ops, next accept right after done.
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_idle();
            m = (i == 0) ? W'(65) : (i == 1) ? W'(123) : W'(42);
            e = (i == 2) ? W'(0) : W'(17);
            bus.m = m; bus.e = e; bus.n = W'(3233);
            model(m, e, W'(3233), xc, xerr, lat);
            sb.push_back('{xc, xerr, cyc + lat});
            @(negedge clk);
            if (i == 2) bus.start = 1'b0;
        end

        // Reset in the middle of an operation: no done, outputs cleared.
        issue(W'(65), W'(17), W'(3233), W'(2790), 1'b0, 780, acc);
        while (cyc < acc + 300) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", W'(bus.busy), W'(0));
        check("midrst_done", W'(bus.done), W'(0));
        check("midrst_c", bus.c, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_busy", W'(bus.busy), W'(0));
        issue(W'(65), W'(17), W'(3233), W'(2790), 1'b0, 780, acc);

        // Drain the scoreboard.
        begin
            int unsigned t = 0;
            while (sb.size() != 0 && t < BUDGET) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (2) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));
        finish_now();
    end
endmodule
